mem_stage_lsu: RTL

Load/store unit for the MEM stage of the 5-stage pipeline: the consumer of the EX/MEM pipeline register outputs. It issues word accesses to the data memory over a req/ack handshake, raises a stall request to the hazard unit while an access is outstanding, and contains the MEM/WB pipeline register feeding writeback. Non-memory instructions pass through with one cycle of latency.

---
 rtl/mem_stage_lsu_if.sv | 34 +++
 rtl/mem_stage_lsu.sv | 116 +++++++++++
 2 files changed

// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the MEM-stage LSU and the data memory.
//   dmem_req   : access request, held high until ack or abort
//   dmem_we    : 1 = store, 0 = load
//   dmem_addr  : word-aligned byte address
//   dmem_wdata : store data
//   dmem_rdata : load data, valid while dmem_ack is high
//   dmem_ack   : one-cycle completion pulse from the memory
// master = LSU side, slave = memory side.
interface mem_stage_lsu_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit with the MEM/WB pipeline register.
// Consumes the EX/MEM register outputs (*M), issues word accesses over the dmem bus,
// requests a pipeline stall while an access is outstanding and drives writeback (*W).
//   clk, rst            : clock, synchronous active-high reset
//   RegWriteM..WriteRegM: instruction from EX/MEM
//   stall_req           : combinational; holds EX/MEM and everything upstream
//   dmem                : data-memory bus (master side)
//   RegWriteW..WriteRegW: registered MEM/WB outputs
//   mem_err             : one-cycle pulse alongside the W load of a misaligned or aborted access
module mem_stage_lsu #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        RegWriteM,
    input  logic        MemtoRegM,
    input  logic        MemWriteM,
    input  logic [31:0] ALUDataM,
    input  logic [31:0] WriteDataM,
    input  logic [4:0]  WriteRegM,
    output logic        stall_req,
    mem_stage_lsu_if.master dmem,
    output logic        RegWriteW,
    output logic        MemtoRegW,
    output logic [31:0] ReadDataW,
    output logic [31:0] ALUDataW,
    output logic [4:0]  WriteRegW,
    output logic        mem_err
);

    localparam logic [15:0] TmoLast = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

    state_t      state;
    logic [15:0] tmo_cnt;
    logic        abort;
    logic [31:0] load_buf;
    logic        memop;
    logic        misaligned;

    always_comb begin
        memop      = MemtoRegM | MemWriteM;
        misaligned = memop & (ALUDataM[1:0] != 2'b00);
        // DONE releases the stall so the held instruction is written back exactly once.
        stall_req  = (state == StBusy) | ((state == StIdle) & memop & ~misaligned);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= StIdle;
            tmo_cnt         <= 16'd0;
            abort           <= 1'b0;
            load_buf        <= 32'd0;
            dmem.dmem_req   <= 1'b0;
            dmem.dmem_we    <= 1'b0;
            dmem.dmem_addr  <= 32'd0;
            dmem.dmem_wdata <= 32'd0;
            RegWriteW       <= 1'b0;
            MemtoRegW       <= 1'b0;
            ReadDataW       <= 32'd0;
            ALUDataW        <= 32'd0;
            WriteRegW       <= 5'd0;
            mem_err         <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    if (memop && !misaligned) begin
                        state           <= StBusy;
                        dmem.dmem_req   <= 1'b1;
                        dmem.dmem_we    <= MemWriteM;
                        dmem.dmem_addr  <= {ALUDataM[31:2], 2'b00};
                        dmem.dmem_wdata <= WriteDataM;
                        tmo_cnt         <= 16'd0;
                    end
                end
                StBusy: begin
                    // An ack in the final allowed cycle still completes the access.
                    if (dmem.dmem_ack) begin
                        load_buf      <= dmem.dmem_rdata;
                        dmem.dmem_req <= 1'b0;
                        state         <= StDone;
                    end else if (tmo_cnt == TmoLast) begin
                        dmem.dmem_req <= 1'b0;
                        abort         <= 1'b1;
                        state         <= StDone;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                    abort <= 1'b0;
                end
                default: state <= StIdle;
            endcase

            if (stall_req) begin
                RegWriteW <= 1'b0;
                MemtoRegW <= 1'b0;
                ReadDataW <= 32'd0;
                ALUDataW  <= 32'd0;
                WriteRegW <= 5'd0;
                mem_err   <= 1'b0;
            end else begin
                RegWriteW <= RegWriteM & ~misaligned & ~abort;
                MemtoRegW <= MemtoRegM & ~misaligned & ~abort;
                ReadDataW <= load_buf;
                ALUDataW  <= ALUDataM;
                WriteRegW <= WriteRegM;
                mem_err   <= misaligned | abort;
            end
        end
    end

endmodule
